version_reporter: RTL and testbench



---
 rtl/version_frame_pkg.sv | 42 ++++
 rtl/version_pkg.sv | 16 +
 rtl/version_tick_gen.sv | 35 +++
 rtl/version_reporter.sv | 107 ++++++++++
 tb/tb_version_reporter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/version_frame_pkg.sv
// Frame layout for the version reporter: length, tag byte, FSM states and
// the lookup of the thirteen constant frame bytes.
package version_frame_pkg;

  import version_pkg::*;

  localparam int         C_FRAME_LEN     = 14;
  localparam logic [7:0] C_TAG_V         = 8'h56;
  localparam int         C_IDX_W         = 4;
  // Index of the last constant byte; the checksum follows it.
  localparam logic [C_IDX_W-1:0] C_LAST_DATA_IDX = C_IDX_W'(C_FRAME_LEN - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_e;

  // Constant frame bytes 0..12; any other index reads as zero.
  function automatic logic [7:0] frame_byte(input logic [C_IDX_W-1:0] idx,
                                            input logic [7:0]         header);
    logic [7:0] b;
    case (idx)
      4'd0:    b = header;
      4'd1:    b = C_TAG_V;
      4'd2:    b = C_VERSION_MAJOR;
      4'd3:    b = C_VERSION_MINOR;
      4'd4:    b = C_VERSION_PATCH;
      4'd5:    b = C_VERSION_BUILD;
      4'd6:    b = C_VERSION_YEAR[15:8];
      4'd7:    b = C_VERSION_YEAR[7:0];
      4'd8:    b = C_VERSION_MONTH;
      4'd9:    b = C_VERSION_DAY;
      4'd10:   b = C_VERSION_HOUR;
      4'd11:   b = C_VERSION_MINUTE;
      4'd12:   b = C_VERSION_SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage : version_frame_pkg

// File: rtl/version_pkg.sv
// Build-identification constants for this bitstream, consumed by the
// version reporter. Values are stamped by the build flow.
package version_pkg;

  localparam logic [7:0]  C_VERSION_MAJOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd72;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2026;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h01;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h07;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h23;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h05;

endpackage : version_pkg

// File: rtl/version_tick_gen.sv
// Free-running period counter for automatic frames. Counts 0..PERIOD-1 and
// pulses tick for the cycle in which it wraps. PERIOD = 0 disables the tick.
module version_tick_gen #(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int          C_CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned C_MAX_INT = (PERIOD == 0) ? 0 : PERIOD - 1;
  localparam logic [C_CNT_W-1:0] C_MAX = C_CNT_W'(C_MAX_INT);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               wrap;

  assign wrap = (cnt_q == C_MAX);
  assign tick = (PERIOD != 0) && wrap;

  // Next count: wrap to zero at the end of the period.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q + C_CNT_W'(1);
    if (wrap) cnt_d = '0;
  end

  // Period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : version_tick_gen

// File: rtl/version_reporter.sv
// Serialises the build-identification constants into a 14-byte frame on a
// valid/ready byte stream: header, 'V', version, date/time, checksum.
// Frames are sent on request and, optionally, every P_AUTO_PERIOD cycles.
module version_reporter
  import version_frame_pkg::*;
#(
  parameter int unsigned P_AUTO_PERIOD = 0,
  parameter logic [7:0]  P_HEADER      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       busy
);

  state_e             state_q, state_d;
  logic [C_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]         acc_q, acc_d;
  logic               pending_q, pending_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               tick;
  logic               hs;

  version_tick_gen #(.PERIOD(P_AUTO_PERIOD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign hs      = valid_q & m_ready;
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign busy    = pending_q | (state_q != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, byte index, running checksum and the one-deep pending flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = SEND;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          acc_d = acc_q + data_q;
          idx_d = idx_q + C_IDX_W'(1);
          if (idx_q == C_LAST_DATA_IDX) state_d = CSUM;
        end
      end
      CSUM: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A request or tick in the same cycle as the final handshake wins over the clear.
    pending_d = req | tick | (pending_q & ~((state_q == CSUM) & hs));
  end

  // Output decode from the next-state values, so outputs leave a register.
  always_comb begin
    valid_d = (state_d != IDLE);
    last_d  = (state_d == CSUM);
    case (state_d)
      SEND:    data_d = frame_byte(idx_d, P_HEADER);
      CSUM:    data_d = 8'h00 - acc_d;
      default: data_d = 8'h00;
    endcase
  end

  // Datapath and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      acc_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

endmodule : version_reporter

// File: tb/tb_version_reporter.sv
// Bench for version_reporter: a cycle table for the first frame, a byte
// scoreboard for backpressure, collapse and reset sequences, and a second
// instance with a 100-cycle auto period.
module tb_version_reporter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Request-driven instance
  logic       rst_n, req, m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, busy;

  // Auto-period instance
  logic       rst1_n, req1, ready1;
  logic [7:0] data1;
  logic       valid1, last1, busy1;

  version_reporter dut (
    .clk (clk), .rst_n (rst_n), .req (req), .m_data (m_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_last (m_last), .busy (busy)
  );

  version_reporter #(.P_AUTO_PERIOD(100)) dut_auto (
    .clk (clk), .rst_n (rst1_n), .req (req1), .m_data (data1),
    .m_valid (valid1), .m_ready (ready1), .m_last (last1), .busy (busy1)
  );

  logic [7:0] exp_frame [14];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected bytes for the request-driven instance
  logic [7:0] sb_q [$];
  int         frames_done = 0;

  task automatic push_frame();
    for (int k = 0; k < 14; k++) sb_q.push_back(exp_frame[k]);
  endtask

  // Monitor: pops one expected byte per handshake, checks stall stability and checksum
  initial begin
    logic       pv, pr, plast;
    logic [7:0] pdata, sum, e;
    int         mon_idx;
    pv = 1'b0; pr = 1'b0; plast = 1'b0; pdata = 8'h00; sum = 8'h00; mon_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; sum = 8'h00; mon_idx = 0;
      end else begin
        if (pv && !pr) begin
          check("stall_valid", int'(m_valid), 1);
          check("stall_data",  int'(m_data),  int'(pdata));
          check("stall_last",  int'(m_last),  int'(plast));
        end
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", m_data, $time);
          end else begin
            e = sb_q.pop_front();
            check("byte", int'(m_data), int'(e));
            check("last", int'(m_last), int'(mon_idx == 13));
            sum = sum + m_data;
            if (mon_idx == 13) begin
              check("checksum", int'(sum), 0);
              frames_done++;
              sum = 8'h00;
              mon_idx = 0;
            end else begin
              mon_idx++;
            end
          end
        end
        pv = m_valid; pr = m_ready; pdata = m_data; plast = m_last;
      end
    end
  end

  // Cycle table for the first frame after reset
  typedef struct {
    logic       req;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eb;
  } vec_t;

  vec_t vt [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, nv, i1;
    logic       pv1;
    logic [7:0] sum1;
    int starts [$];
    int lasts  [$];
    int exp_starts [6] = '{101, 201, 301, 401, 501, 901};
    int exp_lasts  [6] = '{114, 214, 314, 414, 814, 914};

    exp_frame = '{8'hA5, 8'h56, 8'h00, 8'h00, 8'h00, 8'h48, 8'h20,
                  8'h26, 8'h01, 8'h07, 8'h12, 8'h23, 8'h05, 8'h35};

    vt[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    for (int k = 0; k < 14; k++)
      vt[2+k] = '{1'b0, 1'b1, 1'b1, exp_frame[k], (k == 13), 1'b1};
    vt[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; req = 1'b0; m_ready = 1'b1;
    rst1_n = 1'b0; req1 = 1'b0; ready1 = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // First frame, cycle by cycle
    push_frame();
    for (int i = 0; i < 18; i++) begin
      req = vt[i].req;
      m_ready = vt[i].rdy;
      check($sformatf("tbl%0d_valid", i), int'(m_valid), int'(vt[i].ev));
      check($sformatf("tbl%0d_busy", i),  int'(busy),    int'(vt[i].eb));
      check($sformatf("tbl%0d_last", i),  int'(m_last),  int'(vt[i].el));
      if (vt[i].ev) check($sformatf("tbl%0d_data", i), int'(m_data), int'(vt[i].ed));
      step();
    end
    req = 1'b0;

    // Random backpressure, roughly 30 % ready
    push_frame();
    f0 = frames_done;
    req = 1'b1;
    step();
    req = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      m_ready = ($urandom_range(0, 99) < 30);
      step();
      if (frames_done != f0) break;
    end
    m_ready = 1'b1;
    check("bp_frames", frames_done - f0, 1);
    check("bp_sb_empty", sb_q.size(), 0);
    repeat (3) step();
    check("bp_busy_after", int'(busy), 0);

    // Requests during a frame plus one on the final handshake collapse into one follow-on
    push_frame();
    push_frame();
    f0 = frames_done;
    for (int c = 0; c <= 40; c++) begin
      req = (c == 0) || (c == 4) || (c == 7) || (c == 10) || (c == 15);
      m_ready = 1'b1;
      if (c == 15) check("col_final_last", int'(m_last), 1);
      if (c == 16) begin
        check("col_gap_valid", int'(m_valid), 0);
        check("col_gap_busy",  int'(busy),    1);
      end
      if (c == 17) begin
        check("col_next_valid", int'(m_valid), 1);
        check("col_next_byte0", int'(m_data),  8'hA5);
      end
      if (c == 31) begin
        check("col_end_valid", int'(m_valid), 0);
        check("col_end_busy",  int'(busy),    0);
      end
      step();
    end
    req = 1'b0;
    check("col_frames", frames_done - f0, 2);
    check("col_sb_empty", sb_q.size(), 0);

    // Reset while byte 7 is valid
    push_frame();
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (8) step();
    check("rst_byte7_valid", int'(m_valid), 1);
    check("rst_byte7_data",  int'(m_data),  8'h26);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_drop", int'(m_valid), 0);
    check("rst_busy_drop",  int'(busy),    0);
    check("rst_last_drop",  int'(m_last),  0);
    sb_q.delete();
    step();
    step();
    rst_n = 1'b1;
    nv = 0;
    repeat (12) begin
      step();
      if (m_valid) nv++;
    end
    check("rst_silent", nv, 0);
    check("rst_no_pending", int'(busy), 0);
    push_frame();
    f0 = frames_done;
    req = 1'b1;
    step();
    req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (frames_done != f0) break;
    end
    check("rst_new_frame", frames_done - f0, 1);
    check("rst_sb_empty", sb_q.size(), 0);

    // Auto-period instance: ticks every 100 cycles, one 300-cycle stall
    step();
    rst1_n = 1'b1;
    pv1 = 1'b0; i1 = 0; sum1 = 8'h00;
    for (int c = 0; c <= 950; c++) begin
      ready1 = !((c >= 501) && (c <= 800));
      if (c == 800) begin
        check("auto_stall_valid", int'(valid1), 1);
        check("auto_stall_byte0", int'(data1),  8'hA5);
      end
      if (valid1 && !pv1) starts.push_back(c);
      if (valid1 && ready1) begin
        check("auto_byte", int'(data1), int'(exp_frame[i1]));
        check("auto_last", int'(last1), int'(i1 == 13));
        sum1 = sum1 + data1;
        if (i1 == 13) begin
          check("auto_checksum", int'(sum1), 0);
          lasts.push_back(c);
          i1 = 0;
          sum1 = 8'h00;
        end else begin
          i1++;
        end
      end
      pv1 = valid1;
      step();
    end
    check("auto_n_starts", starts.size(), 6);
    check("auto_n_lasts",  lasts.size(),  6);
    for (int i = 0; i < 6; i++) begin
      if (i < starts.size()) check($sformatf("auto_start%0d", i), starts[i], exp_starts[i]);
      if (i < lasts.size())  check($sformatf("auto_lastcyc%0d", i), lasts[i], exp_lasts[i]);
    end
    check("auto_busy_end", int'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_version_reporter
